// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises the raw 5/10 sensors, qualifies pulse width,
// queues accepted coins and issues them as single-cycle codes separated by an idle gap.
module coin_acceptor #(
  parameter int MIN_W = 3,
  parameter int MAX_W = 20,
  parameter int GAP   = 4,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic [1:0] coin_code,
  output logic       reject,
  output logic       fifo_full
);

  localparam int CW = $clog2(MAX_W + 2);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 2);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_W);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_W);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [GW-1:0] GAP_LD  = GW'(GAP);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  logic [1:0]    sync5, sync10;
  logic          s5, s10;
  state_t        state;
  logic          ch;          // latched channel: 0 = 5-unit, 1 = 10-unit
  logic [CW-1:0] cnt;
  logic          lat, oth, in_range, fall, push, pop;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count, count_n;
  logic [GW-1:0] gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync5  <= 2'b00;
      sync10 <= 2'b00;
    end else begin
      sync5  <= {sync5[0], coin5_raw};
      sync10 <= {sync10[0], coin10_raw};
    end
  end

  assign s5  = sync5[1];
  assign s10 = sync10[1];

  assign lat      = ch ? s10 : s5;
  assign oth      = ch ? s5 : s10;
  assign in_range = (cnt >= CNT_MIN) && (cnt <= CNT_MAX);
  assign fall     = (state == MEASURE) && !lat && !oth;
  assign push     = fall && in_range && !fifo_full;
  assign pop      = (count != '0) && (gap == '0);

  // Pulse qualifier; reject is raised once on entry to STUCK or on a full-FIFO drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= 1'b0;
      cnt    <= '0;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (s5 ^ s10) begin
            ch    <= s10;
            cnt   <= CNT_ONE;
            state <= MEASURE;
          end else if (s5 && s10) begin
            reject <= 1'b1;
            state  <= STUCK;
          end
        end
        MEASURE: begin
          if (oth) begin
            reject <= 1'b1;
            state  <= STUCK;
          end else if (lat) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_MAX) begin
              reject <= 1'b1;
              state  <= STUCK;
            end
          end else begin
            if (in_range && fifo_full) reject <= 1'b1;
            state <= IDLE;
          end
        end
        STUCK: begin
          if (!s5 && !s10) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + OCC_ONE;
    else if (pop && !push) count_n = count - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ch ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      count     <= count_n;
      fifo_full <= (count_n == OCC_FULL);
    end
  end

  // Issue stage: one registered code per pop, then GAP idle cycles before the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      coin_code <= 2'b00;
      gap       <= '0;
    end else if (pop) begin
      coin_code <= mem[rp];
      gap       <= GAP_LD;
    end else begin
      coin_code <= 2'b00;
      if (gap != '0) gap <= gap - GAP_ONE;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: default instance plus a GAP=40 instance for queueing cases.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic rst, rst_ov, c5, c10, o5, o10;
  logic [1:0] a_code, o_code;
  logic a_rej, o_rej, a_full, o_full;

  int checks = 0;
  int errors = 0;

  int cyc;
  int a_n5, a_n10, a_n11, a_nrej, a_last, a_min_gap, a_first_code, a_first_rej, a_run, a_max_run;
  int o_n5, o_n10, o_n11, o_nrej, o_last, o_min_gap, o_first_code, o_first_rej, o_first_full;

  always #5 clk = ~clk;

  coin_acceptor dut (
    .clk(clk), .rst(rst), .coin5_raw(c5), .coin10_raw(c10),
    .coin_code(a_code), .reject(a_rej), .fifo_full(a_full)
  );

  coin_acceptor #(.GAP(40)) dut_ov (
    .clk(clk), .rst(rst_ov), .coin5_raw(o5), .coin10_raw(o10),
    .coin_code(o_code), .reject(o_rej), .fifo_full(o_full)
  );

  task automatic clr();
    cyc = 0;
    a_n5 = 0; a_n10 = 0; a_nrej = 0; a_last = -1; a_min_gap = 1000;
    a_first_code = -1; a_first_rej = -1; a_run = 0; a_max_run = 0;
    o_n5 = 0; o_n10 = 0; o_nrej = 0; o_last = -1; o_min_gap = 1000;
    o_first_code = -1; o_first_rej = -1; o_first_full = -1;
  endtask

  // Advance one clock and sample both instances 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (a_code === 2'b11) a_n11++;
    if (a_code === 2'b01) a_n5++;
    if (a_code === 2'b10) a_n10++;
    if (a_code === 2'b01 || a_code === 2'b10) begin
      if (a_last >= 0 && cyc - a_last - 1 < a_min_gap) a_min_gap = cyc - a_last - 1;
      a_last = cyc;
      if (a_first_code < 0) a_first_code = cyc;
    end
    if (a_rej === 1'b1) begin
      a_nrej++; a_run++;
      if (a_first_rej < 0) a_first_rej = cyc;
    end else a_run = 0;
    if (a_run > a_max_run) a_max_run = a_run;
    if (o_code === 2'b11) o_n11++;
    if (o_code === 2'b01) o_n5++;
    if (o_code === 2'b10) o_n10++;
    if (o_code === 2'b01 || o_code === 2'b10) begin
      if (o_last >= 0 && cyc - o_last - 1 < o_min_gap) o_min_gap = cyc - o_last - 1;
      o_last = cyc;
      if (o_first_code < 0) o_first_code = cyc;
    end
    if (o_rej === 1'b1) begin
      o_nrej++;
      if (o_first_rej < 0) o_first_rej = cyc;
    end
    if (o_full === 1'b1 && o_first_full < 0) o_first_full = cyc;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_ov = 1'b1;
    run(2);
    rst = 1'b0; rst_ov = 1'b0;
    checks++; if (a_code !== 2'b00) begin errors++; $display("FAIL rst_code: got %b expected 00", a_code); end
    checks++; if (a_rej !== 1'b0) begin errors++; $display("FAIL rst_reject: got %b expected 0", a_rej); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", a_full); end
    checks++; if (o_code !== 2'b00) begin errors++; $display("FAIL rst_ov_code: got %b expected 00", o_code); end
    checks++; if (o_rej !== 1'b0) begin errors++; $display("FAIL rst_ov_reject: got %b expected 0", o_rej); end
    checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL rst_ov_full: got %b expected 0", o_full); end
  endtask

  task automatic test_valid5();
    clr();
    c5 = 1'b1; run(5); c5 = 1'b0;
    run(3);
    checks++; if (a_code !== 2'b00) begin errors++; $display("FAIL v5_early: got %b expected 00", a_code); end
    run(1);
    checks++; if (a_code !== 2'b01) begin errors++; $display("FAIL v5_code: got %b expected 01", a_code); end
    checks++; if (a_first_code != 9) begin errors++; $display("FAIL v5_latency: got %0d expected 9", a_first_code); end
    run(1);
    checks++; if (a_code !== 2'b00) begin errors++; $display("FAIL v5_single: got %b expected 00", a_code); end
    run(10);
    checks++; if (a_n5 != 1) begin errors++; $display("FAIL v5_count: got %0d expected 1", a_n5); end
    checks++; if (a_nrej != 0) begin errors++; $display("FAIL v5_reject: got %0d expected 0", a_nrej); end
  endtask

  task automatic test_back_to_back();
    clr();
    c10 = 1'b1; run(4); c10 = 1'b0; run(1);
    c10 = 1'b1; run(4); c10 = 1'b0; run(20);
    checks++; if (a_n10 != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", a_n10); end
    checks++; if (a_min_gap != 4) begin errors++; $display("FAIL b2b_gap: got %0d expected 4", a_min_gap); end
    checks++; if (a_nrej != 0) begin errors++; $display("FAIL b2b_reject: got %0d expected 0", a_nrej); end
  endtask

  task automatic test_boundaries();
    clr();
    c5 = 1'b1; run(2); c5 = 1'b0; run(12);
    checks++; if (a_n5 != 0 || a_nrej != 0) begin errors++; $display("FAIL w2_discard: got codes %0d rej %0d expected 0 0", a_n5, a_nrej); end
    c5 = 1'b1; run(3); c5 = 1'b0; run(12);
    checks++; if (a_n5 != 1) begin errors++; $display("FAIL w3_accept: got %0d expected 1", a_n5); end
    c10 = 1'b1; run(20); c10 = 1'b0; run(12);
    checks++; if (a_n10 != 1 || a_nrej != 0) begin errors++; $display("FAIL w20_accept: got codes %0d rej %0d expected 1 0", a_n10, a_nrej); end
    clr();
    c10 = 1'b1; run(21); c10 = 1'b0; run(12);
    checks++; if (a_nrej != 1 || a_n10 != 0) begin errors++; $display("FAIL w21_reject: got rej %0d codes %0d expected 1 0", a_nrej, a_n10); end
    checks++; if (a_first_rej != 23) begin errors++; $display("FAIL w21_timing: got %0d expected 23", a_first_rej); end
  endtask

  task automatic test_glitch_jam();
    clr();
    c5 = 1'b1; run(1); c5 = 1'b0; run(20);
    checks++; if (a_n5 + a_n10 != 0 || a_nrej != 0) begin errors++; $display("FAIL glitch: got codes %0d rej %0d expected 0 0", a_n5 + a_n10, a_nrej); end
    clr();
    c10 = 1'b1; run(30); c10 = 1'b0; run(10);
    checks++; if (a_nrej != 1) begin errors++; $display("FAIL jam_reject: got %0d expected 1", a_nrej); end
    checks++; if (a_first_rej != 23) begin errors++; $display("FAIL jam_timing: got %0d expected 23", a_first_rej); end
    checks++; if (a_max_run != 1) begin errors++; $display("FAIL jam_pulse_len: got %0d expected 1", a_max_run); end
    checks++; if (a_n5 + a_n10 != 0) begin errors++; $display("FAIL jam_code: got %0d expected 0", a_n5 + a_n10); end
    c10 = 1'b1; run(5); c10 = 1'b0; run(10);
    checks++; if (a_n10 != 1 || a_nrej != 1) begin errors++; $display("FAIL jam_recover: got codes %0d rej %0d expected 1 1", a_n10, a_nrej); end
  endtask

  task automatic test_both();
    clr();
    c5 = 1'b1; c10 = 1'b1; run(6); c5 = 1'b0; c10 = 1'b0; run(10);
    checks++; if (a_nrej != 1) begin errors++; $display("FAIL both_reject: got %0d expected 1", a_nrej); end
    checks++; if (a_n5 + a_n10 != 0) begin errors++; $display("FAIL both_code: got %0d expected 0", a_n5 + a_n10); end
    c5 = 1'b1; run(4); c5 = 1'b0; run(10);
    checks++; if (a_n5 != 1 || a_nrej != 1) begin errors++; $display("FAIL both_recover: got codes %0d rej %0d expected 1 1", a_n5, a_nrej); end
  endtask

  task automatic test_overflow();
    clr();
    for (int k = 0; k < 6; k++) begin
      o5 = 1'b1; run(4); o5 = 1'b0; run(2);
    end
    run(2);
    checks++; if (o_first_full != 31) begin errors++; $display("FAIL ov_full_time: got %0d expected 31", o_first_full); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ov_full: got %b expected 1", o_full); end
    checks++; if (o_nrej != 1 || o_first_rej != 37) begin errors++; $display("FAIL ov_reject: got %0d at %0d expected 1 at 37", o_nrej, o_first_rej); end
    checks++; if (o_n5 != 1) begin errors++; $display("FAIL ov_first_issue: got %0d expected 1", o_n5); end
    run(250);
    checks++; if (o_n5 != 5) begin errors++; $display("FAIL ov_codes: got %0d expected 5", o_n5); end
    checks++; if (o_min_gap != 40) begin errors++; $display("FAIL ov_gap: got %0d expected 40", o_min_gap); end
    checks++; if (o_nrej != 1) begin errors++; $display("FAIL ov_reject_total: got %0d expected 1", o_nrej); end
  endtask

  task automatic test_reset_mid();
    rst_ov = 1'b1; run(1); rst_ov = 1'b0;
    clr();
    for (int k = 0; k < 3; k++) begin
      o5 = 1'b1; run(4); o5 = 1'b0; run(2);
    end
    o10 = 1'b1; run(6);
    rst_ov = 1'b1; o10 = 1'b0; run(1); rst_ov = 1'b0;
    checks++; if (o_code !== 2'b00 || o_rej !== 1'b0 || o_full !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got %b %b %b expected 00 0 0", o_code, o_rej, o_full);
    end
    clr();
    run(60);
    checks++; if (o_n5 + o_n10 != 0) begin errors++; $display("FAIL mid_rst_lost: got %0d expected 0", o_n5 + o_n10); end
    checks++; if (o_nrej != 0) begin errors++; $display("FAIL mid_rst_reject: got %0d expected 0", o_nrej); end
    o5 = 1'b1; run(4); o5 = 1'b0; run(10);
    checks++; if (o_n5 != 1 || o_first_code != 68) begin errors++; $display("FAIL mid_rst_after: got %0d at %0d expected 1 at 68", o_n5, o_first_code); end
  endtask

  initial begin
    rst = 1'b1; rst_ov = 1'b1;
    c5 = 1'b0; c10 = 1'b0; o5 = 1'b0; o10 = 1'b0;
    a_n11 = 0; o_n11 = 0;
    clr();
    test_reset();
    test_valid5();
    test_back_to_back();
    test_boundaries();
    test_glitch_jam();
    test_both();
    test_overflow();
    test_reset_mid();
    checks++; if (a_n11 != 0 || o_n11 != 0) begin errors++; $display("FAIL code11: got %0d %0d expected 0 0", a_n11, o_n11); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Upstream front end for vending_machine.
- Synchronises and validates the raw 5-unit and 10-unit coin sensor pulses, rejects malformed pulses, and buffers accepted coins in a small FIFO.
- Presents each accepted coin to the vending FSM's in[1:0] input as a single-cycle code (2'b01 = 5, 2'b10 = 10), separated by a guaranteed idle gap.

Parameters:
- MIN_W, 3: minimum synchronised high width in clocks for a valid coin; shorter pulses are glitches.
- MAX_W, 20: maximum valid high width in clocks; longer pulses are a stuck or jammed sensor.
- GAP, 4: minimum number of idle (2'b00) cycles on coin_code between two coin codes.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- coin5_raw  input  1  asynchronous 5-unit coin sensor, high while the coin passes.
- coin10_raw  input  1  asynchronous 10-unit coin sensor, high while the coin passes.
- coin_code  output  2  to vending_machine in; 2'b00 idle, 2'b01 = 5, 2'b10 = 10; 2'b11 is never driven.
- reject  output  1  one-cycle pulse: coin routed to the return chute.
- fifo_full  output  1  high while the FIFO holds DEPTH entries.

Behaviour:
- Reset: one clock is synchronous, active-high rst.
  - On rst, all state clears: coin_code=2'b00, reject=0, fifo_full=0, FIFO empty, FSM in IDLE, synchronisers 0.
  - The gap counter clears to "expired", so the first coin may be issued immediately.
  - rst overrides any operation in progress, including MEASURE and STUCK; a coin being measured is discarded with no reject pulse.
- Input path: each raw input passes through a 2-FF synchroniser. All decisions use the synchronised signals s5 and s10.
- FSM states: IDLE, MEASURE, STUCK.
  - IDLE, s5 xor s10 = 1: latch the channel, width counter = 1, go to MEASURE.
  - IDLE, s5 & s10: one-cycle reject, go to STUCK.
  - MEASURE, latched channel still high, other channel low: increment the counter (saturating at MAX_W+1).
    - If the counter reaches MAX_W+1: one-cycle reject, go to STUCK.
  - MEASURE, other channel goes high: one-cycle reject, go to STUCK.
  - MEASURE, latched channel low with counter in [MIN_W, MAX_W]:
    - FIFO not full: push the code, go to IDLE.
    - FIFO full: one-cycle reject, no push, go to IDLE.
  - MEASURE, latched channel low with counter < MIN_W: silent discard (no reject), go to IDLE.
  - STUCK: wait until s5=0 and s10=0, then go to IDLE. Only one reject per event.
- FIFO:
  - DEPTH entries of 2 bits each.
  - Simultaneous push and pop in the same cycle is legal; occupancy is unchanged, including when full.
  - Pop happens only when an entry is issued.
  - Pointers wrap modulo DEPTH.
- Output issue:
  - When the FIFO is non-empty and the gap counter has expired: pop the head, register it onto coin_code for exactly one cycle, load the gap counter with GAP.
  - coin_code is 2'b00 for the following GAP cycles, minimum.
  - coin_code is driven only from a register.
- Latency with an empty FIFO and expired gap:
  - Let E0 be the first clk edge at which the raw input is sampled low.
  - The push occurs at E2.
  - coin_code shows the code during the cycle following E3.
- reject and fifo_full are registered. reject is never high for two consecutive cycles per event.

Test Plan:
- Valid 5 coin: coin5_raw high 5 cycles, default parameters → coin_code=2'b01 for exactly 1 cycle, 3 edges after the fall is sampled; reject stays 0.
- Valid 10 coins back to back: two coin10_raw pulses of 4 cycles each, 1 cycle apart → two 2'b10 pulses separated by ≥4 idle cycles.
- Glitch and jam:
  - coin5_raw high 1 cycle → no code, no reject.
  - coin10_raw high 30 cycles → exactly one reject pulse about 21 cycles after the rise, no code, FSM back in IDLE after release.
- Both sensors high together → single reject, no code; next valid 5 coin is accepted normally.
- Overflow: GAP=40, six valid 5 coins of width 4, 2 cycles apart:
  - fifo_full asserts once 4 coins are buffered (the first coin is issued immediately).
  - The coin arriving while fifo_full=1 gets reject=1.
  - Five 2'b01 codes are emitted, each ≥40 idle cycles apart.
- Reset mid-operation: rst for 1 cycle during MEASURE of a 10 coin, with 2 coins queued → all outputs 0, queued coins lost, no code and no reject from the interrupted coin; a subsequent valid coin is accepted.
